// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus controller and its address decoder.
package dbus_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_SLV   = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned OFS_W_MEM = 28;
    localparam int unsigned OFS_W_IO  = 20;

    localparam int unsigned SLV_ROM   = 0;
    localparam int unsigned SLV_RAM   = 1;
    localparam int unsigned SLV_UART  = 2;
    localparam int unsigned SLV_CPUID = 3;

    localparam logic [ADDR_W-OFS_W_MEM-1:0] TAG_ROM   = 4'h0;
    localparam logic [ADDR_W-OFS_W_MEM-1:0] TAG_RAM   = 4'h1;
    localparam logic [ADDR_W-OFS_W_IO-1:0]  TAG_UART  = 12'hf00;
    localparam logic [ADDR_W-OFS_W_IO-1:0]  TAG_CPUID = 12'hf01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Request as latched from the CPU port and replayed to the slaves.
    typedef struct packed {
        logic              drw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    // Pick the 32-bit slice of the packed slave read bus addressed by a one-hot select.
    function automatic logic [DATA_W-1:0] slice_sel(
        input logic [NUM_SLV*DATA_W-1:0] bus,
        input logic [NUM_SLV-1:0]        sel
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel[i]) r = r | bus[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/dbus_decode.sv
// Combinational address decoder: byte address to one-hot slave select and zero-extended offset.
module dbus_decode
    import dbus_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic [ADDR_W-1:0]  offset,
    output logic               unmapped
);

    always_comb begin
        sel      = '0;
        offset   = '0;
        unmapped = 1'b0;
        if (addr[ADDR_W-1:OFS_W_MEM] == TAG_ROM) begin
            sel[SLV_ROM] = 1'b1;
            offset       = ADDR_W'(addr[OFS_W_MEM-1:0]);
        end else if (addr[ADDR_W-1:OFS_W_MEM] == TAG_RAM) begin
            sel[SLV_RAM] = 1'b1;
            offset       = ADDR_W'(addr[OFS_W_MEM-1:0]);
        end else if (addr[ADDR_W-1:OFS_W_IO] == TAG_UART) begin
            sel[SLV_UART] = 1'b1;
            offset        = ADDR_W'(addr[OFS_W_IO-1:0]);
        end else if (addr[ADDR_W-1:OFS_W_IO] == TAG_CPUID) begin
            sel[SLV_CPUID] = 1'b1;
            offset         = ADDR_W'(addr[OFS_W_IO-1:0]);
        end else begin
            unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/mod_dbus_ctrl.sv
// Data-bus controller: latches one CPU request, runs it against a single slave with
// a ready/timeout handshake, and returns read data while stalling the CPU.
module mod_dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_de,
    input  logic                        cpu_drw,
    input  logic [ADDR_W-1:0]           cpu_daddr,
    input  logic [DATA_W-1:0]           cpu_din,
    output logic [DATA_W-1:0]           cpu_dout,
    output logic                        cpu_stall,
    output logic [NUM_SLV-1:0]          slv_de,
    output logic                        slv_drw,
    output logic [ADDR_W-1:0]           slv_daddr,
    output logic [DATA_W-1:0]           slv_din,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_dout,
    input  logic [NUM_SLV-1:0]          slv_rdy,
    output logic                        bus_err,
    input  logic                        err_clr
);

    state_t              state_q, state_d;
    req_t                req_q, req_d;
    logic [NUM_SLV-1:0]  de_q, de_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                err_q, err_d, err_set;

    logic [NUM_SLV-1:0]  dec_sel;
    logic [ADDR_W-1:0]   dec_offset;
    logic                dec_unmapped;
    logic                sel_rdy;
    logic                timeout_hit;

    dbus_decode u_decode (
        .addr     (cpu_daddr),
        .sel      (dec_sel),
        .offset   (dec_offset),
        .unmapped (dec_unmapped)
    );

    // slv_de holds the latched select during ACCESS, so it doubles as the select register.
    assign sel_rdy     = |(slv_rdy & de_q);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_de) state_d = dec_unmapped ? DONE : ACCESS;
            ACCESS:  if (sel_rdy || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; ready beats timeout in the same cycle.
    always_comb begin
        de_d    = '0;
        req_d   = req_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_de) begin
                    if (dec_unmapped) begin
                        dout_d  = '0;
                        err_set = 1'b1;
                    end else begin
                        req_d.drw  = cpu_drw;
                        req_d.addr = dec_offset;
                        req_d.data = cpu_din;
                        de_d       = dec_sel;
                        cnt_d      = '0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel_rdy) begin
                    dout_d = req_q.drw ? '0 : slice_sel(slv_dout, de_q);
                end else if (timeout_hit) begin
                    dout_d  = '0;
                    err_set = 1'b1;
                end else begin
                    de_d = de_q;
                end
            end
            default: ;
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= '0;
            de_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            req_q  <= req_d;
            de_q   <= de_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            err_q  <= err_d;
        end
    end

    assign slv_de    = de_q;
    assign slv_drw   = req_q.drw;
    assign slv_daddr = req_q.addr;
    assign slv_din   = req_q.data;
    assign cpu_dout  = dout_q;
    assign bus_err   = err_q;
    assign cpu_stall = cpu_de & (state_q != DONE);

endmodule

// File: tb/tb_mod_dbus_ctrl.sv
// Directed self-checking bench for mod_dbus_ctrl with TIMEOUT=16.
module tb_mod_dbus_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_de;
    logic         cpu_drw;
    logic [31:0]  cpu_daddr;
    logic [31:0]  cpu_din;
    logic [31:0]  cpu_dout;
    logic         cpu_stall;
    logic [3:0]   slv_de;
    logic         slv_drw;
    logic [31:0]  slv_daddr;
    logic [31:0]  slv_din;
    logic [127:0] slv_dout;
    logic [3:0]   slv_rdy;
    logic         bus_err;
    logic         err_clr;

    int checks = 0;
    int errors = 0;
    int n_access;

    localparam logic [127:0] DOUT_VAL = {32'h017d7840, 32'h00005a5a, 32'hdeadbeef, 32'hc0de0008};

    always #5 clk = ~clk;

    mod_dbus_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_de    (cpu_de),
        .cpu_drw   (cpu_drw),
        .cpu_daddr (cpu_daddr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .slv_de    (slv_de),
        .slv_drw   (slv_drw),
        .slv_daddr (slv_daddr),
        .slv_din   (slv_din),
        .slv_dout  (slv_dout),
        .slv_rdy   (slv_rdy),
        .bus_err   (bus_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_de    = 1'b0;
        cpu_drw   = 1'b0;
        cpu_daddr = '0;
        cpu_din   = '0;
        slv_dout  = DOUT_VAL;
        slv_rdy   = 4'hf;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_slv_de",  32'(slv_de),   32'h0);
        check("rst_dout",    cpu_dout,      32'h0);
        check("rst_err",     32'(bus_err),  32'h0);
        check("rst_stall",   32'(cpu_stall), 32'h0);
        rst = 1'b0;
        tick;

        // cpuid read, zero wait
        cpu_de = 1'b1; cpu_drw = 1'b0; cpu_daddr = 32'hf0100004;
        #1;
        check("id_stall0",  32'(cpu_stall), 32'h1);
        check("id_de0",     32'(slv_de),    32'h0);
        tick;
        check("id_de1",     32'(slv_de),    32'h8);
        check("id_addr1",   slv_daddr,      32'h4);
        check("id_stall1",  32'(cpu_stall), 32'h1);
        tick;
        check("id_stall2",  32'(cpu_stall), 32'h0);
        check("id_dout2",   cpu_dout,       32'h017d7840);
        check("id_de2",     32'(slv_de),    32'h0);
        cpu_de = 1'b0;
        tick;

        // unmapped read, then clear
        cpu_de = 1'b1; cpu_daddr = 32'h20000000;
        #1;
        check("um_stall0",  32'(cpu_stall), 32'h1);
        tick;
        check("um_stall1",  32'(cpu_stall), 32'h0);
        check("um_dout",    cpu_dout,       32'h0);
        check("um_err",     32'(bus_err),   32'h1);
        check("um_de",      32'(slv_de),    32'h0);
        cpu_de = 1'b0; err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("um_clr",     32'(bus_err),   32'h0);

        // second unmapped access in the same cycle as err_clr: set wins
        cpu_de = 1'b1; cpu_daddr = 32'h20000000;
        tick;
        cpu_de = 1'b0;
        tick;
        cpu_de = 1'b1; err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("um2_err",    32'(bus_err),   32'h1);
        cpu_de = 1'b0;
        tick;
        check("um2_err_idle", 32'(bus_err), 32'h1);

        // ROM read while the error flag is pending
        cpu_de = 1'b1; cpu_daddr = 32'h00000008;
        tick;
        check("rom_de",     32'(slv_de),    32'h1);
        check("rom_addr",   slv_daddr,      32'h8);
        tick;
        check("rom_dout",   cpu_dout,       32'hc0de0008);
        check("rom_stall",  32'(cpu_stall), 32'h0);
        check("rom_err",    32'(bus_err),   32'h1);
        cpu_de = 1'b0;
        tick;

        // reset in the middle of a stalled UART write
        cpu_de = 1'b1; cpu_drw = 1'b1; cpu_daddr = 32'hf0000020; cpu_din = 32'h12345678;
        slv_rdy = 4'b1011;
        tick;
        check("mr_de",      32'(slv_de),    32'h4);
        check("mr_drw",     32'(slv_drw),   32'h1);
        check("mr_din",     slv_din,        32'h12345678);
        tick;
        #2 rst = 1'b1;
        #1;
        check("mr_rst_de",    32'(slv_de),    32'h0);
        check("mr_rst_drw",   32'(slv_drw),   32'h0);
        check("mr_rst_addr",  slv_daddr,      32'h0);
        check("mr_rst_din",   slv_din,        32'h0);
        check("mr_rst_dout",  cpu_dout,       32'h0);
        check("mr_rst_err",   32'(bus_err),   32'h0);
        check("mr_rst_stall", 32'(cpu_stall), 32'h1);
        @(posedge clk);
        #1;
        cpu_drw = 1'b0; cpu_daddr = 32'h00000008; cpu_din = '0; slv_rdy = 4'hf;
        rst = 1'b0;
        #1;
        check("pr_stall0",  32'(cpu_stall), 32'h1);
        tick;
        check("pr_de1",     32'(slv_de),    32'h1);
        check("pr_addr1",   slv_daddr,      32'h8);
        tick;
        check("pr_stall2",  32'(cpu_stall), 32'h0);
        check("pr_dout2",   cpu_dout,       32'hc0de0008);
        cpu_de = 1'b0;
        tick;

        // UART read that times out
        cpu_de = 1'b1; cpu_daddr = 32'hf0000020; slv_rdy = 4'b1011;
        tick;
        check("to_addr",    slv_daddr,      32'h20);
        n_access = 0;
        while (slv_de == 4'b0100 && n_access < 40) begin
            n_access++;
            tick;
        end
        check("to_cycles",  32'(n_access),  32'd16);
        check("to_stall",   32'(cpu_stall), 32'h0);
        check("to_dout",    cpu_dout,       32'h0);
        check("to_err",     32'(bus_err),   32'h1);
        cpu_de = 1'b0; err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("to_clr",     32'(bus_err),   32'h0);

        // ready arriving on the last ACCESS cycle completes normally
        cpu_de = 1'b1; cpu_daddr = 32'hf0000020; slv_rdy = 4'b1011;
        tick;
        repeat (15) tick;
        check("lr_de",      32'(slv_de),    32'h4);
        slv_rdy = 4'hf;
        tick;
        check("lr_stall",   32'(cpu_stall), 32'h0);
        check("lr_dout",    cpu_dout,       32'h00005a5a);
        check("lr_err",     32'(bus_err),   32'h0);
        cpu_de = 1'b0;
        tick;

        // RAM write with three wait cycles
        cpu_de = 1'b1; cpu_drw = 1'b1; cpu_daddr = 32'h10000010; cpu_din = 32'ha5a5a5a5;
        slv_rdy = 4'b1101;
        #1;
        check("wr_stall0",  32'(cpu_stall), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 4) slv_rdy = 4'hf;
            check("wr_de",    32'(slv_de),    32'h2);
            check("wr_addr",  slv_daddr,      32'h10);
            check("wr_din",   slv_din,        32'ha5a5a5a5);
            check("wr_drw",   32'(slv_drw),   32'h1);
            check("wr_stall", 32'(cpu_stall), 32'h1);
        end
        tick;
        check("wr_stall5",  32'(cpu_stall), 32'h0);
        check("wr_dout5",   cpu_dout,       32'h0);
        check("wr_de5",     32'(slv_de),    32'h0);
        check("wr_err5",    32'(bus_err),   32'h0);
        cpu_de = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
